echo_remove: RTL

- Inverse (de-echo) filter for the single-tap echo stage.
- Removes a known echo `y[n] = x[n] + a*x[n-D]` by computing the recursive inverse `x[n] = y[n] - a*x[n-D]`.
- Sits after the echo/LPF chain; used for A/B listening and for self-check loops (echo -> echo_remove should return the dry signal).
- Sample-strobed, with a ready/valid handshake; samples are stored in a circular buffer of its own reconstructed output.

---
 rtl/echo_pkg.sv | 26 ++
 rtl/echo_dpram.sv | 36 +++
 rtl/echo_remove.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/echo_pkg.sv
// echo_pkg: shared types and constants for the echo-removal datapath.
//   sample_t   - signed Q1.15 audio sample
//   alpha_t    - signed Q1.15 echo gain
//   sat_res_t  - a clamped sample together with a flag that the clamp engaged
//   rm_state_t - sequencing states of echo_remove
package echo_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic signed [15:0] alpha_t;

    localparam sample_t           SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t           SAMPLE_MIN = 16'sh8000;
    localparam logic signed [31:0] ROUND_HALF = 32'sd16384;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CALC
    } rm_state_t;

    typedef struct packed {
        sample_t val;
        logic    sat;
    } sat_res_t;

endpackage

// File: rtl/echo_dpram.sv
// echo_dpram: simple dual-port RAM, one write port and one registered read
// port on a single clock. Written generically so synthesis infers block RAM
// and a vendor macro can replace it without touching the caller.
//   clk     - clock
//   we      - write enable
//   wr_addr - write address
//   wr_data - write data
//   rd_addr - read address, sampled every clock
//   rd_data - registered read data (old data on a same-address write)
module echo_dpram
    import echo_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DW-1:0]     rd_data
);

    logic [DW-1:0] mem [0:(2**ADDR_W)-1];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/echo_remove.sv
// echo_remove: recursive inverse of the single-tap echo stage.
// Reconstructs x[n] = y[n] - a*x[n-D] from the echoed input y, keeping its own
// reconstructed output in a circular buffer so the delayed term is available.
//   clk, rst   - clock, synchronous active-high reset
//   in_valid   - input sample strobe; accepted only while in_ready is high
//   in_ready   - high in IDLE (one sample in flight at a time)
//   in_data    - signed Q1.15 echoed sample
//   delay_time - echo delay D in samples, captured on accept
//   alpha      - signed Q1.15 echo gain, captured on accept
//   out_valid  - one-cycle strobe, 3 edges after accept
//   out_data   - reconstructed (dry) sample, saturated
//   sat_flag   - pulses with out_valid when either clamp engaged
module echo_remove
    import echo_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DW     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic [ADDR_W-1:0]    delay_time,
    input  logic signed [15:0]   alpha,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    output logic                 sat_flag
);

    localparam logic [ADDR_W-1:0] FILL_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    // Rounded product, clamped at the top only: -1.0 * -1.0 is the single
    // product that overflows, and no product can underflow.
    function automatic sat_res_t round_clamp(input logic signed [31:0] p);
        logic signed [32:0] s;
        sat_res_t           res;
        s = (33'(p) + 33'(ROUND_HALF)) >>> 15;
        if (s > 33'sd32767) begin
            res.val = SAMPLE_MAX;
            res.sat = 1'b1;
        end else begin
            res.val = s[15:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

    function automatic sat_res_t sat_sub(input sample_t x, input sample_t e);
        logic signed [16:0] r;
        sat_res_t           res;
        r = 17'(x) - 17'(e);
        if (r > 17'sd32767) begin
            res.val = SAMPLE_MAX;
            res.sat = 1'b1;
        end else if (r < -17'sd32768) begin
            res.val = SAMPLE_MIN;
            res.sat = 1'b1;
        end else begin
            res.val = r[15:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

    rm_state_t         state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [ADDR_W-1:0] dly_q, dly_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    sample_t           x_q, x_d;
    alpha_t            a_q, a_d;
    logic              out_valid_q, out_valid_d;
    sample_t           out_data_q, out_data_d;
    logic              sat_flag_q, sat_flag_d;

    logic              ram_we;
    logic [DW-1:0]     ram_q;
    sample_t           d_term;
    logic signed [31:0] prod;
    sat_res_t          e_res;
    sat_res_t          r_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_flag_q  <= sat_flag_d;
        end
        // operand latches are only meaningful while a sample is in flight
        x_q       <= x_d;
        a_q       <= a_d;
        dly_q     <= dly_d;
        rd_addr_q <= rd_addr_d;
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        dly_d       = dly_q;
        rd_addr_d   = rd_addr_q;
        x_d         = x_q;
        a_d         = a_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        sat_flag_d  = 1'b0;
        ram_we      = 1'b0;
        d_term      = '0;
        prod        = '0;
        e_res       = '0;
        r_res       = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d       = in_data;
                    a_d       = alpha;
                    dly_d     = delay_time;
                    rd_addr_d = wr_ptr_q - delay_time;
                    state_d   = RD;
                end
            end
            RD: begin
                // RAM reads rd_addr_q on this edge; data is ready in CALC
                state_d = CALC;
            end
            CALC: begin
                // Until D outputs exist the slot holds stale/uninitialised
                // data, so the delayed term is forced to zero.
                if (dly_q != '0 && fill_cnt_q >= dly_q) begin
                    d_term = ram_q;
                end
                prod        = 32'(a_q) * 32'(d_term);
                e_res       = round_clamp(prod);
                r_res       = sat_sub(x_q, e_res.val);
                out_data_d  = r_res.val;
                out_valid_d = 1'b1;
                sat_flag_d  = e_res.sat | r_res.sat;
                ram_we      = 1'b1;
                wr_ptr_d    = wr_ptr_q + ONE;
                if (fill_cnt_q != FILL_MAX) begin
                    fill_cnt_d = fill_cnt_q + ONE;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A reset landing on the CALC edge drops the sample without writing it.
    echo_dpram #(
        .ADDR_W (ADDR_W),
        .DW     (DW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we & ~rst),
        .wr_addr (wr_ptr_q),
        .wr_data (out_data_d),
        .rd_addr (rd_addr_q),
        .rd_data (ram_q)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_flag_q;

endmodule
